// File: rtl/aes_pkg.sv
// Shared AES constants and ShiftRows index helpers. Byte n sits at row n[1:0] and column n[3:2],
// so a source index is {source_column, row}.
package aes_pkg;

  localparam int unsigned AES_BLOCK_BYTES = 16;

  // Source byte for InvShiftRows: row r rotated right by r.
  function automatic logic [3:0] inv_shift_rows_src(input logic [3:0] n);
    logic [1:0] row_s;
    logic [1:0] col_s;
    row_s = n[1:0];
    col_s = n[3:2] - row_s;
    return {col_s, row_s};
  endfunction

  // Source byte for forward ShiftRows: row r rotated left by r.
  function automatic logic [3:0] shift_rows_src(input logic [3:0] n);
    logic [1:0] row_s;
    logic [1:0] col_s;
    row_s = n[1:0];
    col_s = n[3:2] + row_s;
    return {col_s, row_s};
  endfunction

endpackage

// File: rtl/aes_pingpong_buf.sv
// Two 16-byte banks written in order and read through an arbitrary index.
// The write side and the read side each own one bank at a time.
module aes_pingpong_buf
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [3:0] rd_cnt,
  input  logic [3:0] rd_idx,
  output logic [7:0] rd_data
);

  localparam logic [3:0] LAST_IDX = 4'(AES_BLOCK_BYTES - 1);

  logic [7:0] mem_r [2][AES_BLOCK_BYTES];
  logic [1:0] full_r;
  logic [1:0] full_nxt_s;
  logic [1:0] set_s;
  logic [1:0] clr_s;
  logic       wbank_r;
  logic       rbank_r;
  logic [3:0] wcnt_r;
  logic [3:0] rcnt_r;
  logic       wr_fire_s;
  logic       rd_fire_s;
  logic       wr_done_s;
  logic       rd_done_s;

  assign wr_ready  = ~full_r[wbank_r];
  assign rd_valid  = full_r[rbank_r];
  assign rd_cnt    = rcnt_r;
  assign rd_data   = mem_r[rbank_r][rd_idx];
  assign wr_fire_s = wr_valid & wr_ready;
  assign rd_fire_s = rd_valid & rd_ready;
  assign wr_done_s = wr_fire_s & (wcnt_r == LAST_IDX);
  assign rd_done_s = rd_fire_s & (rcnt_r == LAST_IDX);

  // Fill and drain completion always target different banks, so both apply.
  always_comb begin
    set_s      = {wr_done_s & wbank_r, wr_done_s & ~wbank_r};
    clr_s      = {rd_done_s & rbank_r, rd_done_s & ~rbank_r};
    full_nxt_s = (full_r | set_s) & ~clr_s;
  end

  // Bank pointers, byte counters and full flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r  <= 2'b00;
      wbank_r <= 1'b0;
      rbank_r <= 1'b0;
      wcnt_r  <= 4'd0;
      rcnt_r  <= 4'd0;
    end else begin
      full_r <= full_nxt_s;
      if (wr_fire_s) begin
        wcnt_r <= wcnt_r + 4'd1;
        if (wr_done_s) wbank_r <= ~wbank_r;
      end
      if (rd_fire_s) begin
        rcnt_r <= rcnt_r + 4'd1;
        if (rd_done_s) rbank_r <= ~rbank_r;
      end
    end
  end

  // Bank storage; contents are don't-care until their full flag is set.
  always_ff @(posedge clk) begin
    if (wr_fire_s) mem_r[wbank_r][wcnt_r] <= wr_data;
  end

endmodule

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial (Inv)ShiftRows: buffers a 16-byte state and replays it through
// the row-rotation permutation, one byte per handshake on each side.
module inv_shift_rows_stream
  import aes_pkg::*;
#(
  parameter int INVERSE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last
);

  logic [3:0] rd_cnt_s;
  logic [3:0] src_idx_s;
  logic [7:0] rd_data_s;
  logic       rd_valid_s;

  aes_pingpong_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (in_byte),
    .rd_valid (rd_valid_s),
    .rd_ready (out_ready),
    .rd_cnt   (rd_cnt_s),
    .rd_idx   (src_idx_s),
    .rd_data  (rd_data_s)
  );

  // Output byte n is fetched from its pre-rotation position.
  always_comb begin
    src_idx_s = 4'd0;
    if (INVERSE != 0) begin
      src_idx_s = inv_shift_rows_src(rd_cnt_s);
    end else begin
      src_idx_s = shift_rows_src(rd_cnt_s);
    end
  end

  assign out_valid = rd_valid_s;
  assign out_byte  = rd_valid_s ? rd_data_s : 8'h00;
  assign out_last  = rd_valid_s & (rd_cnt_s == 4'hF);

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Scoreboard bench: stimulus pushes expected bytes, a negedge monitor pops them on output handshakes.
module tb_inv_shift_rows_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  // Index 0: INVERSE=1 dut, 1: INVERSE=0 dut, 2: loopback pair (fwd input, inv output).
  logic       in_valid_a  [3];
  logic       in_ready_a  [3];
  logic [7:0] in_byte_a   [3];
  logic       out_valid_a [3];
  logic       out_ready_a [3];
  logic [7:0] out_byte_a  [3];
  logic       out_last_a  [3];
  logic       mid_valid, mid_ready, mid_last;
  logic [7:0] mid_byte;

  inv_shift_rows_stream #(.INVERSE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_byte(in_byte_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_byte(out_byte_a[0]), .out_last(out_last_a[0]));
  inv_shift_rows_stream #(.INVERSE(0)) dut_fwd (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_byte(in_byte_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_byte(out_byte_a[1]), .out_last(out_last_a[1]));
  inv_shift_rows_stream #(.INVERSE(0)) lb_fwd (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .in_byte(in_byte_a[2]),
    .out_valid(mid_valid), .out_ready(mid_ready), .out_byte(mid_byte), .out_last(mid_last));
  inv_shift_rows_stream #(.INVERSE(1)) lb_inv (
    .clk(clk), .rst(rst), .in_valid(mid_valid), .in_ready(mid_ready), .in_byte(mid_byte),
    .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .out_byte(out_byte_a[2]), .out_last(out_last_a[2]));

  int inv_perm [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
  int fwd_perm [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
  string tags [3] = '{"inv", "fwd", "loop"};

  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  logic [8:0] q2 [$];
  int compared = 0;
  int mismatched = 0;
  logic       stall_a [3];
  logic [7:0] hold_a  [3];
  logic       lb_done;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: actual event/timeout expected none", name);
  endtask

  task automatic push_block(input int which, input logic [7:0] base);
    logic [8:0] e;
    for (int n = 0; n < 16; n++) begin
      e = {(n == 15), base + 8'((which == 0) ? inv_perm[n] : fwd_perm[n])};
      if (which == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // Present a byte and return at the negedge preceding the accepting edge.
  task automatic send_byte(input int which, input logic [7:0] b, output int waits);
    @(posedge clk); #1;
    in_valid_a[which] = 1'b1;
    in_byte_a[which]  = b;
    waits = 0;
    @(negedge clk);
    while (!in_ready_a[which] && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready_a[which]) fail({tags[which], "_send_timeout"});
  endtask

  task automatic idle(input int which);
    @(posedge clk); #1;
    in_valid_a[which] = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 300) begin
      t++;
      @(negedge clk);
    end
    if ((q0.size() + q1.size() + q2.size()) != 0) fail("drain_timeout");
  endtask

  task automatic check_out(input int w);
    logic [8:0] e;
    int have;
    if (out_valid_a[w] && out_ready_a[w]) begin
      have = (w == 0) ? q0.size() : (w == 1) ? q1.size() : q2.size();
      if (have == 0) begin
        fail({tags[w], "_unexpected_output"});
      end else begin
        if (w == 0) e = q0.pop_front();
        else if (w == 1) e = q1.pop_front();
        else e = q2.pop_front();
        cmp({tags[w], "_byte"}, 32'(out_byte_a[w]), 32'(e[7:0]));
        cmp({tags[w], "_last"}, 32'(out_last_a[w]), 32'(e[8]));
      end
    end
    if (!out_valid_a[w]) begin
      cmp({tags[w], "_idle_byte"}, 32'(out_byte_a[w]), 32'h0);
      cmp({tags[w], "_idle_last"}, 32'(out_last_a[w]), 32'h0);
    end
  endtask

  // Monitor: handshakes complete at the next posedge, so pop at this negedge.
  always @(negedge clk) begin
    for (int w = 0; w < 3; w++) begin
      if (rst) begin
        stall_a[w] = 1'b0;
      end else begin
        if (stall_a[w]) begin
          cmp({tags[w], "_hold_valid"}, 32'(out_valid_a[w]), 32'h1);
          cmp({tags[w], "_hold_byte"}, 32'(out_byte_a[w]), 32'(hold_a[w]));
        end
        check_out(w);
        stall_a[w] = out_valid_a[w] && !out_ready_a[w];
        hold_a[w]  = out_byte_a[w];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, tot, t, hs;
    rst = 1'b1;
    lb_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i] = 1'b0; in_byte_a[i] = 8'h00; out_ready_a[i] = 1'b1; stall_a[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cmp({tags[i], "_rst_in_ready"}, 32'(in_ready_a[i]), 32'h1);
      cmp({tags[i], "_rst_out_valid"}, 32'(out_valid_a[i]), 32'h0);
    end

    // Single inverse block with latency check.
    push_block(0, 8'h00);
    for (int n = 0; n < 16; n++) send_byte(0, 8'(n), w);
    cmp("lat_pre_valid", 32'(out_valid_a[0]), 32'h0);
    idle(0);
    @(negedge clk);
    cmp("lat_first_valid", 32'(out_valid_a[0]), 32'h1);
    wait_drain();

    // Forward mode.
    push_block(1, 8'h00);
    for (int n = 0; n < 16; n++) send_byte(1, 8'(n), w);
    idle(1);
    wait_drain();

    // Three back-to-back blocks: no input stall, no output bubble.
    push_block(0, 8'h40); push_block(0, 8'h50); push_block(0, 8'h60);
    fork
      begin
        tot = 0;
        for (int n = 0; n < 48; n++) begin
          send_byte(0, 8'h40 + 8'(n), w);
          tot += w;
        end
        cmp("stream_in_stalls", 32'(tot), 32'h0);
        idle(0);
      end
      begin
        t = 0;
        @(negedge clk);
        while (!out_valid_a[0] && t < 60) begin t++; @(negedge clk); end
        if (!out_valid_a[0]) fail("stream_first_valid_timeout");
        for (int k = 0; k < 48; k++) begin
          cmp("stream_valid", 32'(out_valid_a[0]), 32'h1);
          cmp("stream_last", 32'(out_last_a[0]), 32'((k % 16) == 15));
          @(negedge clk);
        end
      end
    join
    wait_drain();

    // Backpressure: two banks fill, then in_ready returns after 16th drain.
    @(posedge clk); #1 out_ready_a[0] = 1'b0;
    push_block(0, 8'h10); push_block(0, 8'h20);
    tot = 0;
    for (int n = 0; n < 32; n++) begin
      send_byte(0, 8'h10 + 8'(n), w);
      tot += w;
    end
    cmp("bp_accept_stalls", 32'(tot), 32'h0);
    @(posedge clk); #1 in_byte_a[0] = 8'h30;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmp("bp_full_in_ready", 32'(in_ready_a[0]), 32'h0);
    end
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    out_ready_a[0] = 1'b1;
    hs = 0;
    for (int k = 0; k < 40 && hs < 16; k++) begin
      @(negedge clk);
      if (out_valid_a[0] && out_ready_a[0]) hs++;
    end
    if (hs == 16) begin
      cmp("bp_ready_before_free", 32'(in_ready_a[0]), 32'h0);
      @(negedge clk);
      cmp("bp_ready_after_free", 32'(in_ready_a[0]), 32'h1);
    end else begin
      fail("bp_handshake_timeout");
    end
    wait_drain();

    // Reset mid-block discards the partial block.
    for (int n = 0; n < 7; n++) send_byte(0, 8'hA0 + 8'(n), w);
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    cmp("rst_mid_in_ready", 32'(in_ready_a[0]), 32'h1);
    cmp("rst_mid_out_valid", 32'(out_valid_a[0]), 32'h0);
    push_block(0, 8'h00);
    for (int n = 0; n < 16; n++) send_byte(0, 8'(n), w);
    idle(0);
    wait_drain();

    // Loopback: forward then inverse must reproduce the input under random stalls.
    fork
      begin
        logic [7:0] b;
        for (int blk = 0; blk < 100; blk++) begin
          for (int n = 0; n < 16; n++) begin
            b = 8'($urandom);
            q2.push_back({(n == 15), b});
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk); #1 in_valid_a[2] = 1'b0;
            end
            send_byte(2, b, w);
          end
        end
        idle(2);
        lb_done = 1'b1;
      end
      begin
        while (!lb_done) begin
          @(posedge clk); #1;
          out_ready_a[2] = ($urandom_range(0, 3) != 0);
        end
        out_ready_a[2] = 1'b1;
      end
    join
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
